// File: rtl/elevator_call_scheduler_pkg.sv
// Shared definitions for the elevator call scheduler: state encoding,
// floor-number width and the largest supported building.
package elevator_call_scheduler_pkg;

    localparam int FLOOR_W    = 4;
    localparam int MAX_FLOORS = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SWEEP_UP   = 2'd1,
        ST_SWEEP_DOWN = 2'd2,
        ST_DOOR       = 2'd3
    } sched_state_t;

    // One-hot mask for a floor number over the full 16-floor space.
    function automatic logic [MAX_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] floor);
        floor_bit = MAX_FLOORS'(1) << floor;
    endfunction

endpackage

// File: rtl/elevator_call_scheduler_floor_select.sv
// Nearest pending floor in one direction, current floor inclusive.
// up=1 returns the lowest pending floor >= current_floor,
// up=0 returns the highest pending floor <= current_floor.
module floor_select
    import elevator_call_scheduler_pkg::*;
(
    input  logic [MAX_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  up,
    output logic                  found,
    output logic [FLOOR_W-1:0]    floor
);

    // Scan away from the car so the last hit is the nearest one.
    always_comb begin
        found = 1'b0;
        floor = current_floor;
        if (up) begin
            for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
                if (pending[i] && (FLOOR_W'(i) >= current_floor)) begin
                    found = 1'b1;
                    floor = FLOOR_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < MAX_FLOORS; i++) begin
                if (pending[i] && (FLOOR_W'(i) <= current_floor)) begin
                    found = 1'b1;
                    floor = FLOOR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// LOOK-scheduling call scheduler: latches floor calls into a pending
// bitmap, picks the next target for the car controller and holds the
// door open for a fixed dwell at each served floor.
module elevator_call_scheduler
    import elevator_call_scheduler_pkg::*;
#(
    parameter int          FLOORS       = 10,
    parameter logic [31:0] DWELL_CYCLES = 32'd20000000
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               call_valid,
    input  logic [FLOOR_W-1:0] call_floor,
    input  logic [FLOOR_W-1:0] current_floor,
    input  logic               car_idle,
    output logic [FLOOR_W-1:0] requested_floor,
    output logic [FLOORS-1:0]  pending,
    output logic               door_open,
    output logic               dir_up,
    output logic               busy
);

    sched_state_t          state, state_next;
    logic [FLOOR_W-1:0]    req_next;
    logic                  dir_next;
    logic [31:0]           dwell, dwell_next;
    logic [FLOORS-1:0]     pending_next;
    logic [MAX_FLOORS-1:0] pend_ext;
    logic [MAX_FLOORS-1:0] clr_ext;
    logic [MAX_FLOORS-1:0] set_ext;
    logic                  any_above, any_below, at_cur, arrival;
    logic                  up_found, dn_found;
    logic [FLOOR_W-1:0]    up_floor, dn_floor;

    // Widen to 16 floors so any 4-bit floor number indexes safely.
    assign pend_ext = MAX_FLOORS'(pending);
    assign at_cur   = pend_ext[current_floor];

    assign door_open = (state == ST_DOOR);
    assign busy      = (state != ST_IDLE) || (|pending);

    assign arrival = ((state == ST_SWEEP_UP) || (state == ST_SWEEP_DOWN)) &&
                     car_idle && (current_floor == requested_floor) && at_cur;

    floor_select u_sel_up (
        .pending       (pend_ext),
        .current_floor (current_floor),
        .up            (1'b1),
        .found         (up_found),
        .floor         (up_floor)
    );

    floor_select u_sel_dn (
        .pending       (pend_ext),
        .current_floor (current_floor),
        .up            (1'b0),
        .found         (dn_found),
        .floor         (dn_floor)
    );

    // Strictly-above / strictly-below pending calls, used by IDLE.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (pend_ext[i] && (FLOOR_W'(i) > current_floor)) any_above = 1'b1;
            if (pend_ext[i] && (FLOOR_W'(i) < current_floor)) any_below = 1'b1;
        end
    end

    // Next state, target floor, direction, dwell count and served-floor clear.
    always_comb begin
        state_next = state;
        req_next   = requested_floor;
        dir_next   = dir_up;
        dwell_next = dwell;
        clr_ext    = '0;
        unique case (state)
            ST_IDLE: begin
                req_next = current_floor;
                if (any_above) begin
                    state_next = ST_SWEEP_UP;
                    dir_next   = 1'b1;
                    req_next   = up_floor;
                end else if (any_below) begin
                    state_next = ST_SWEEP_DOWN;
                    dir_next   = 1'b0;
                    req_next   = dn_floor;
                end else if (at_cur && car_idle) begin
                    state_next = ST_DOOR;
                    clr_ext    = floor_bit(current_floor);
                    dwell_next = DWELL_CYCLES;
                end
            end
            ST_SWEEP_UP: begin
                if (arrival) begin
                    state_next = ST_DOOR;
                    clr_ext    = floor_bit(current_floor);
                    dwell_next = DWELL_CYCLES;
                end else if (pending == '0) begin
                    state_next = ST_IDLE;
                end else if (up_found) begin
                    dir_next = 1'b1;
                    req_next = up_floor;
                end else begin
                    state_next = ST_SWEEP_DOWN;
                    dir_next   = 1'b0;
                    req_next   = dn_floor;
                end
            end
            ST_SWEEP_DOWN: begin
                if (arrival) begin
                    state_next = ST_DOOR;
                    clr_ext    = floor_bit(current_floor);
                    dwell_next = DWELL_CYCLES;
                end else if (pending == '0) begin
                    state_next = ST_IDLE;
                end else if (dn_found) begin
                    dir_next = 1'b0;
                    req_next = dn_floor;
                end else begin
                    state_next = ST_SWEEP_UP;
                    dir_next   = 1'b1;
                    req_next   = up_floor;
                end
            end
            ST_DOOR: begin
                // Target is frozen while the door is open; on the last dwell
                // cycle the next target is chosen so it appears as the door closes.
                if (dwell <= 32'd1) begin
                    dwell_next = '0;
                    if (pending == '0) begin
                        state_next = ST_IDLE;
                    end else if ((dir_up && up_found) || (!dir_up && !dn_found)) begin
                        state_next = ST_SWEEP_UP;
                        dir_next   = 1'b1;
                        req_next   = up_floor;
                    end else begin
                        state_next = ST_SWEEP_DOWN;
                        dir_next   = 1'b0;
                        req_next   = dn_floor;
                    end
                end else begin
                    dwell_next = dwell - 32'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Call capture: a call to the floor being cleared, or to the car's floor
    // while the door is open, is absorbed; out-of-range floors fall off the slice.
    always_comb begin
        set_ext = '0;
        if (call_valid) set_ext = floor_bit(call_floor) & ~clr_ext;
        if ((state == ST_DOOR) && (call_floor == current_floor)) set_ext = '0;
        pending_next = (pending & ~clr_ext[FLOORS-1:0]) | set_ext[FLOORS-1:0];
    end

    // Register all scheduler state; reset returns every output to idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            pending         <= '0;
            requested_floor <= '0;
            dir_up          <= 1'b1;
            dwell           <= '0;
        end else begin
            state           <= state_next;
            pending         <= pending_next;
            requested_floor <= req_next;
            dir_up          <= dir_next;
            dwell           <= dwell_next;
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: table-driven per-cycle vectors with a
// scoreboard of expected outputs, plus reset sequences around the table.
module tb_elevator_call_scheduler;

    localparam int FLOORS = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             call_valid = 1'b0;
    logic [3:0]       call_floor = 4'd0;
    logic [3:0]       current_floor = 4'd0;
    logic             car_idle = 1'b1;
    logic [3:0]       requested_floor;
    logic [FLOORS-1:0] pending;
    logic             door_open;
    logic             dir_up;
    logic             busy;

    int applied = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] req;
        logic [9:0] pend;
        logic       door;
        logic       dir;
        logic       busy;
    } exp_t;

    typedef struct {
        logic       cv;
        logic [3:0] cf;
        logic [3:0] cur;
        logic       idle;
        exp_t       exp;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    elevator_call_scheduler #(
        .FLOORS       (FLOORS),
        .DWELL_CYCLES (32'd4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .call_valid      (call_valid),
        .call_floor      (call_floor),
        .current_floor   (current_floor),
        .car_idle        (car_idle),
        .requested_floor (requested_floor),
        .pending         (pending),
        .door_open       (door_open),
        .dir_up          (dir_up),
        .busy            (busy)
    );

    function automatic exp_t mk_exp(input logic [3:0] req, input logic [9:0] pend,
                                    input logic door, input logic dir, input logic bsy);
        exp_t e;
        e.req  = req;
        e.pend = pend;
        e.door = door;
        e.dir  = dir;
        e.busy = bsy;
        return e;
    endfunction

    task automatic add(input logic cv, input logic [3:0] cf, input logic [3:0] cur,
                       input logic idle, input logic [3:0] req, input logic [9:0] pend,
                       input logic door, input logic dir, input logic bsy);
        vec_t v;
        v.cv   = cv;
        v.cf   = cf;
        v.cur  = cur;
        v.idle = idle;
        v.exp  = mk_exp(req, pend, door, dir, bsy);
        tbl.push_back(v);
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        applied++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: no expected entry queued", tag);
        end else begin
            e = sb.pop_front();
            if (requested_floor !== e.req || pending !== e.pend || door_open !== e.door ||
                dir_up !== e.dir || busy !== e.busy) begin
                miscompares++;
                $display("FAIL %s: got req=%0d pend=%03h door=%0b dir=%0b busy=%0b, want req=%0d pend=%03h door=%0b dir=%0b busy=%0b",
                         tag, requested_floor, pending, door_open, dir_up, busy,
                         e.req, e.pend, e.door, e.dir, e.busy);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        call_valid    = v.cv;
        call_floor    = v.cf;
        current_floor = v.cur;
        car_idle      = v.idle;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded 100000 time units");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        vec_t v;

        // Reset held with a call strobed: nothing may be captured.
        rst_n = 1'b0;
        call_valid = 1'b1;
        call_floor = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mk_exp(4'd0, 10'h000, 1'b0, 1'b1, 1'b0));
        check_now("reset_hold");
        call_valid = 1'b0;
        #2 rst_n = 1'b1;
        v.cv = 1'b0; v.cf = 4'd0; v.cur = 4'd0; v.idle = 1'b1;
        v.exp = mk_exp(4'd0, 10'h000, 1'b0, 1'b1, 1'b0);
        apply(v, "reset_release");

        //   cv cf    cur   idle  req   pend     door dir busy
        // Single call to 5 from floor 0, serve, dwell of 4, back to IDLE.
        add(1, 4'd5, 4'd0, 1, 4'd0, 10'h020, 0, 1, 1);
        add(0, 4'd0, 4'd0, 1, 4'd5, 10'h020, 0, 1, 1);
        add(0, 4'd0, 4'd0, 0, 4'd5, 10'h020, 0, 1, 1);
        add(0, 4'd0, 4'd5, 1, 4'd5, 10'h000, 1, 1, 1);
        add(0, 4'd0, 4'd5, 1, 4'd5, 10'h000, 1, 1, 1);
        add(0, 4'd0, 4'd5, 1, 4'd5, 10'h000, 1, 1, 1);
        add(0, 4'd0, 4'd5, 1, 4'd5, 10'h000, 1, 1, 1);
        add(0, 4'd0, 4'd5, 1, 4'd5, 10'h000, 0, 1, 0);
        add(0, 4'd0, 4'd5, 1, 4'd5, 10'h000, 0, 1, 0);
        // Sweep up 3->7, retarget to 5, call 1 behind waits; door absorbs calls.
        add(0, 4'd0, 4'd3, 1, 4'd3, 10'h000, 0, 1, 0);
        add(1, 4'd7, 4'd3, 1, 4'd3, 10'h080, 0, 1, 1);
        add(0, 4'd0, 4'd3, 1, 4'd7, 10'h080, 0, 1, 1);
        add(1, 4'd5, 4'd3, 0, 4'd7, 10'h0A0, 0, 1, 1);
        add(0, 4'd0, 4'd3, 0, 4'd5, 10'h0A0, 0, 1, 1);
        add(1, 4'd1, 4'd4, 0, 4'd5, 10'h0A2, 0, 1, 1);
        add(0, 4'd0, 4'd5, 0, 4'd5, 10'h0A2, 0, 1, 1);
        add(1, 4'd5, 4'd5, 1, 4'd5, 10'h082, 1, 1, 1);
        add(1, 4'd5, 4'd5, 1, 4'd5, 10'h082, 1, 1, 1);
        add(1, 4'd12, 4'd5, 1, 4'd5, 10'h082, 1, 1, 1);
        add(0, 4'd0, 4'd5, 1, 4'd5, 10'h082, 1, 1, 1);
        add(0, 4'd0, 4'd5, 1, 4'd7, 10'h082, 0, 1, 1);
        add(0, 4'd0, 4'd6, 0, 4'd7, 10'h082, 0, 1, 1);
        add(0, 4'd0, 4'd7, 1, 4'd7, 10'h002, 1, 1, 1);
        add(0, 4'd0, 4'd7, 1, 4'd7, 10'h002, 1, 1, 1);
        add(0, 4'd0, 4'd7, 1, 4'd7, 10'h002, 1, 1, 1);
        add(0, 4'd0, 4'd7, 1, 4'd7, 10'h002, 1, 1, 1);
        add(0, 4'd0, 4'd7, 1, 4'd1, 10'h002, 0, 0, 1);
        add(0, 4'd0, 4'd4, 0, 4'd1, 10'h002, 0, 0, 1);
        add(0, 4'd0, 4'd1, 1, 4'd1, 10'h000, 1, 0, 1);
        add(0, 4'd0, 4'd1, 1, 4'd1, 10'h000, 1, 0, 1);
        add(0, 4'd0, 4'd1, 1, 4'd1, 10'h000, 1, 0, 1);
        add(0, 4'd0, 4'd1, 1, 4'd1, 10'h000, 1, 0, 1);
        add(0, 4'd0, 4'd1, 1, 4'd1, 10'h000, 0, 0, 0);
        add(0, 4'd0, 4'd1, 1, 4'd1, 10'h000, 0, 0, 0);
        // Car at 5 with calls 8 and 2: up to 8 first, then reverse to 2.
        add(0, 4'd0, 4'd5, 1, 4'd5, 10'h000, 0, 0, 0);
        add(1, 4'd8, 4'd5, 1, 4'd5, 10'h100, 0, 0, 1);
        add(1, 4'd2, 4'd5, 1, 4'd8, 10'h104, 0, 1, 1);
        add(0, 4'd0, 4'd6, 0, 4'd8, 10'h104, 0, 1, 1);
        add(0, 4'd0, 4'd8, 1, 4'd8, 10'h004, 1, 1, 1);
        add(0, 4'd0, 4'd8, 1, 4'd8, 10'h004, 1, 1, 1);
        add(0, 4'd0, 4'd8, 1, 4'd8, 10'h004, 1, 1, 1);
        add(0, 4'd0, 4'd8, 1, 4'd8, 10'h004, 1, 1, 1);
        add(0, 4'd0, 4'd8, 1, 4'd2, 10'h004, 0, 0, 1);
        add(0, 4'd0, 4'd2, 1, 4'd2, 10'h000, 1, 0, 1);
        add(0, 4'd0, 4'd2, 1, 4'd2, 10'h000, 1, 0, 1);
        add(0, 4'd0, 4'd2, 1, 4'd2, 10'h000, 1, 0, 1);
        add(0, 4'd0, 4'd2, 1, 4'd2, 10'h000, 1, 0, 1);
        add(0, 4'd0, 4'd2, 1, 4'd2, 10'h000, 0, 0, 0);
        // Call at the car's own floor from IDLE opens the door directly.
        add(1, 4'd2, 4'd2, 1, 4'd2, 10'h004, 0, 0, 1);
        add(0, 4'd0, 4'd2, 1, 4'd2, 10'h000, 1, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a dwell, checked before any edge.
        #2 rst_n = 1'b0;
        #1;
        sb.push_back(mk_exp(4'd0, 10'h000, 1'b0, 1'b1, 1'b0));
        check_now("async_reset_door");
        @(posedge clk);
        #2 rst_n = 1'b1;
        v.cv = 1'b0; v.cf = 4'd0; v.cur = 4'd2; v.idle = 1'b1;
        v.exp = mk_exp(4'd2, 10'h000, 1'b0, 1'b1, 1'b0);
        apply(v, "post_reset_idle");
        v.cv = 1'b1; v.cf = 4'd3;
        v.exp = mk_exp(4'd2, 10'h008, 1'b0, 1'b1, 1'b1);
        apply(v, "post_reset_call");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
